// File: rtl/viterbi_decoder_param.sv
// Parametrised rate-1/2 hard-decision Viterbi decoder with register-exchange survivors.
// Define VITERBI_ERASURE_EN to add the cx_erase port (an erased code bit adds 0 to the branch metric).
module viterbi_decoder_param #(
  parameter int unsigned  K        = 3,
  parameter logic [K-1:0] G0       = 3'b111,
  parameter logic [K-1:0] G1       = 3'b101,
  parameter int unsigned  TB_DEPTH = 15,
  parameter int unsigned  PMW      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       cx_valid,
  input  logic [1:0] cx,
`ifdef VITERBI_ERASURE_EN
  input  logic [1:0] cx_erase,
`endif
  output logic       d,
  output logic       d_valid
);

  localparam int unsigned SW = K - 1;
  localparam int unsigned N  = 1 << SW;
  localparam int unsigned CW = $clog2(TB_DEPTH);
  localparam int unsigned PW = TB_DEPTH - 1;

  typedef logic [PMW-1:0] pm_t;
  typedef logic [PW-1:0]  path_t;
  typedef logic [SW-1:0]  st_t;

  localparam pm_t           PM_MAX   = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TB_DEPTH - 1);

  pm_t           pm_q   [N];
  pm_t           pm_d   [N];
  path_t         path_q [N];
  path_t         path_d [N];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          d_q, d_d;
  logic          d_valid_q, d_valid_d;

  logic [1:0]          erase_c;
  pm_t                 new_pm   [N];
  logic [TB_DEPTH-1:0] new_path [N];
  pm_t                 min_pm_c;
  st_t                 best_c;

`ifdef VITERBI_ERASURE_EN
  assign erase_c = cx_erase;
`else
  assign erase_c = 2'b00;
`endif

  // Hamming distance between received symbol and the branch label of transition {p, b}.
  function automatic logic [1:0] branch_metric(input st_t p, input logic b,
                                               input logic [1:0] sym, input logic [1:0] era);
    logic [K-1:0] r;
    logic         m0;
    logic         m1;
    r  = {p, b};
    m0 = (sym[0] ^ (^(r & G0))) & ~era[0];
    m1 = (sym[1] ^ (^(r & G1))) & ~era[1];
    return {1'b0, m0} + {1'b0, m1};
  endfunction

  function automatic pm_t sat_add(input pm_t a, input logic [1:0] bm);
    logic [PMW:0] sum;
    sum = {1'b0, a} + (PMW+1)'(bm);
    return sum[PMW] ? PM_MAX : sum[PMW-1:0];
  endfunction

  // Add-compare-select per next state; ties keep the p0 survivor.
  always_comb begin : acs
    st_t ns;
    st_t p0;
    st_t p1;
    pm_t c0;
    pm_t c1;
    ns = '0;
    p0 = '0;
    p1 = '0;
    c0 = '0;
    c1 = '0;
    for (int unsigned s = 0; s < N; s++) begin
      ns = st_t'(s);
      p0 = ns >> 1;
      p1 = p0 | (st_t'(1) << (K - 2));
      c0 = sat_add(pm_q[p0], branch_metric(p0, ns[0], cx, erase_c));
      c1 = sat_add(pm_q[p1], branch_metric(p1, ns[0], cx, erase_c));
      if (c1 < c0) begin
        new_pm[s]   = c1;
        new_path[s] = {path_q[p1], ns[0]};
      end else begin
        new_pm[s]   = c0;
        new_path[s] = {path_q[p0], ns[0]};
      end
    end
  end

  // Minimum new metric and its state, lowest index winning ties.
  always_comb begin : best_state
    min_pm_c = new_pm[0];
    best_c   = '0;
    for (int unsigned s = 1; s < N; s++) begin
      if (new_pm[s] < min_pm_c) begin
        min_pm_c = new_pm[s];
        best_c   = st_t'(s);
      end
    end
  end

  // The survivor MSB only feeds d, so storage keeps TB_DEPTH-1 bits per state.
  always_comb begin : next_state
    pm_d      = pm_q;
    path_d    = path_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    d_valid_d = 1'b0;
    if (clear) begin
      for (int unsigned s = 0; s < N; s++) begin
        pm_d[s]   = (s == 0) ? pm_t'(0) : PM_MAX;
        path_d[s] = '0;
      end
      cnt_d = '0;
      d_d   = 1'b0;
    end else if (cx_valid) begin
      for (int unsigned s = 0; s < N; s++) begin
        pm_d[s]   = new_pm[s] - min_pm_c;
        path_d[s] = new_path[s][PW-1:0];
      end
      if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        d_d       = new_path[best_c][TB_DEPTH-1];
        d_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < N; s++) begin
        pm_q[s]   <= (s == 0) ? pm_t'(0) : PM_MAX;
        path_q[s] <= '0;
      end
      cnt_q     <= '0;
      d_q       <= 1'b0;
      d_valid_q <= 1'b0;
    end else begin
      pm_q      <= pm_d;
      path_q    <= path_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign d       = d_q;
  assign d_valid = d_valid_q;

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// Directed, table-driven bench for viterbi_decoder_param at default parameters.
// Erasure vectors are included when VITERBI_ERASURE_EN is defined.
module tb_viterbi_decoder_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       cx_valid;
  logic [1:0] cx;
`ifdef VITERBI_ERASURE_EN
  logic [1:0] cx_erase;
`endif
  logic       d;
  logic       d_valid;

  always #5 clk = ~clk;

  viterbi_decoder_param dut (
    .clk      (clk),
    .reset    (rst_n),
    .clear    (clear),
    .cx_valid (cx_valid),
    .cx       (cx),
`ifdef VITERBI_ERASURE_EN
    .cx_erase (cx_erase),
`endif
    .d        (d),
    .d_valid  (d_valid)
  );

  typedef struct {
    logic       clr;
    logic       vld;
    logic [1:0] sym;
    logic [1:0] era;
    logic       exp_dv;
    logic       chk_d;
    logic       exp_d;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   strobes  = 0;

  // Hand-encoded message 1,0,1,1,0,0 (encoder returns to state 0, so zeros follow).
  logic [1:0] msg_cx_tab  [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
  logic       msg_bit_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  function automatic logic [1:0] msg_cx(input int i);
    return (i < 6) ? msg_cx_tab[i] : 2'b00;
  endfunction

  function automatic logic msg_bit(input int i);
    return (i >= 0 && i < 6) ? msg_bit_tab[i] : 1'b0;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic clr, input logic vld, input logic [1:0] sym,
                      input logic [1:0] era, input logic exp_dv, input logic chk_d,
                      input logic exp_d);
    vec_t v;
    v.clr = clr; v.vld = vld; v.sym = sym; v.era = era;
    v.exp_dv = exp_dv; v.chk_d = chk_d; v.exp_d = exp_d;
    vecs.push_back(v);
  endtask

  // Message stream of nsym symbols; optional bit error, cx_valid gaps and c0 erasures.
  task automatic build_msg(input int nsym, input int err_idx, input int gap_max,
                           input int era_a, input int era_b);
    logic       last_d;
    logic       have_last;
    logic [1:0] sym;
    logic [1:0] era;
    logic       dv;
    int         g;
    have_last = 1'b0;
    last_d    = 1'b0;
    for (int i = 0; i < nsym; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(1, gap_max)) : 0;
      for (int j = 0; j < g; j++)
        push(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'b00, 1'b0, have_last, last_d);
      sym = (i == err_idx) ? 2'b00 : msg_cx(i);
      era = (i == era_a || i == era_b) ? 2'b01 : 2'b00;
      dv  = (i >= 14);
      push(1'b0, 1'b1, sym, era, dv, dv, msg_bit(i - 14));
      if (dv) begin
        have_last = 1'b1;
        last_d    = msg_bit(i - 14);
      end
    end
  endtask

  task automatic run_vecs(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      clear    = vecs[i].clr;
      cx_valid = vecs[i].vld;
      cx       = vecs[i].sym;
`ifdef VITERBI_ERASURE_EN
      cx_erase = vecs[i].era;
`endif
      @(posedge clk);
      #1;
      if (d_valid === 1'b1) strobes++;
      check_bit($sformatf("%s[%0d].d_valid", name, i), d_valid, vecs[i].exp_dv);
      if (vecs[i].chk_d) check_bit($sformatf("%s[%0d].d", name, i), d, vecs[i].exp_d);
    end
    vecs.delete();
    clear    = 1'b0;
    cx_valid = 1'b0;
    cx       = 2'b00;
`ifdef VITERBI_ERASURE_EN
    cx_erase = 2'b00;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check_bit("reset.d", d, 1'b0);
    check_bit("reset.d_valid", d_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear    = 1'b0;
    cx_valid = 1'b0;
    cx       = 2'b00;
`ifdef VITERBI_ERASURE_EN
    cx_erase = 2'b00;
`endif
    rst_n    = 1'b1;
    #2;

    // All-zero channel: first strobe on the 15th symbol, 26 strobes of d=0.
    do_reset();
    for (int i = 0; i < 40; i++) push(1'b0, 1'b1, 2'b00, 2'b00, i >= 14, i >= 14, 1'b0);
    strobes = 0;
    run_vecs("zeros");
    check_int("zeros.strobe_count", strobes, 26);

    // Clean message.
    do_reset();
    build_msg(40, -1, 0, -1, -1);
    run_vecs("msg");

    // Single bit error on symbol 3 (10 -> 00) is corrected.
    do_reset();
    build_msg(40, 3, 0, -1, -1);
    run_vecs("msg_err");

    // Random 1-3 cycle valid gaps with junk cx: no strobes in gaps, d holds.
    do_reset();
    build_msg(40, -1, 3, -1, -1);
    run_vecs("msg_gaps");

`ifdef VITERBI_ERASURE_EN
    // c0 erased on symbols 1 and 4.
    do_reset();
    build_msg(40, -1, 0, 1, 4);
    run_vecs("msg_erase");
`endif

    // Clear with cx_valid=1 after 20 symbols drops that symbol and restarts the latency.
    do_reset();
    build_msg(20, -1, 0, -1, -1);
    push(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
    build_msg(15, -1, 0, -1, -1);
    run_vecs("clear");
    check_bit("pre_async.d", d, 1'b1);

    // Async reset mid-cycle clears outputs before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("async.d", d, 1'b0);
    check_bit("async.d_valid", d_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) push(1'b0, 1'b1, 2'b00, 2'b00, i == 14, 1'b1, 1'b0);
    run_vecs("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
